// File: rtl/pdm_capture_if.sv
// FIFO-side write port of the PDM capture stage: PCM word, 2-clock write strobe, full flag.
interface pdm_capture_if #(
    parameter int unsigned DW = 8
);
    logic [DW-1:0] sample;
    logic          wr;
    logic          full;

    modport master (output sample, output wr, input full);
    modport slave  (input sample, input wr, output full);
endinterface

// File: rtl/pdm_capture.sv
// PDM microphone capture: mic clock generation, 2-flop sampling, ones-count decimation to PCM words.
// Define PDM_CAPTURE_SIGNED_EN to emit two's-complement words instead of raw unsigned counts.
module pdm_capture #(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned WINDOW      = 255,
    parameter int unsigned DW          = 8,
    parameter int unsigned SETTLE_BITS = 1024
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_enable,
    input  logic          i_mic_data,
    output logic          o_mic_clk,
    output logic          o_mic_lrsel,
    output logic          o_overrun,
    output logic          o_busy,
    pdm_capture_if.master fifo
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SET_W = (SETTLE_BITS > 1) ? $clog2(SETTLE_BITS) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, STROBE} state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [SET_W-1:0] r_settle_cnt;
    logic [DW-1:0]    r_ones_cnt;
    logic [DW-1:0]    r_bit_cnt;
    logic [DW-1:0]    r_sample;
    logic             r_mic_s1;
    logic             r_mic_s2;
    logic             r_mic_clk;
    logic             r_stb;
    logic             r_wr;
    logic             r_overrun;
    logic             r_busy;

    logic             w_div_term;
    logic             w_bit_tick;
    logic             w_window_end;
    logic [DW-1:0]    w_ones_next;
    logic [DW-1:0]    w_word;

    // A bit tick is the clock on which mic_clk falls; the mic drives data on the rising edge.
    assign w_div_term   = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_bit_tick   = (r_state != IDLE) && w_div_term && r_mic_clk;
    assign w_window_end = (r_bit_cnt == DW'(WINDOW - 1));
    assign w_ones_next  = r_ones_cnt + DW'(r_mic_s2);
`ifdef PDM_CAPTURE_SIGNED_EN
    assign w_word = w_ones_next ^ (DW'(1) << (DW - 1));
`else
    assign w_word = w_ones_next;
`endif

    assign o_mic_clk   = r_mic_clk;
    assign o_mic_lrsel = 1'b0;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;
    assign fifo.sample = r_sample;
    assign fifo.wr     = r_wr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_div_cnt    <= '0;
            r_settle_cnt <= '0;
            r_ones_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_sample     <= '0;
            r_mic_s1     <= 1'b0;
            r_mic_s2     <= 1'b0;
            r_mic_clk    <= 1'b0;
            r_stb        <= 1'b0;
            r_wr         <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mic_s1 <= i_mic_data;
            r_mic_s2 <= r_mic_s1;

            if (r_state != IDLE) begin
                if (w_div_term) begin
                    r_div_cnt <= '0;
                    r_mic_clk <= ~r_mic_clk;
                end else begin
                    r_div_cnt <= r_div_cnt + DIV_W'(1);
                end
            end

            // Accumulation keeps running through the strobe so no mic bit is lost.
            if (w_bit_tick && (r_state == ACCUM || r_state == STROBE)) begin
                if (w_window_end) begin
                    r_ones_cnt <= '0;
                    r_bit_cnt  <= '0;
                end else begin
                    r_ones_cnt <= w_ones_next;
                    r_bit_cnt  <= r_bit_cnt + DW'(1);
                end
            end

            // State transitions are last so that going idle overrides the divider update.
            case (r_state)
                IDLE: begin
                    if (i_enable) begin
                        r_state      <= SETTLE;
                        r_busy       <= 1'b1;
                        r_overrun    <= 1'b0;
                        r_settle_cnt <= '0;
                        r_ones_cnt   <= '0;
                        r_bit_cnt    <= '0;
                        r_div_cnt    <= '0;
                        r_mic_clk    <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (!i_enable) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_div_cnt <= '0;
                        r_mic_clk <= 1'b0;
                    end else if (w_bit_tick) begin
                        if (r_settle_cnt == SET_W'(SETTLE_BITS - 1)) begin
                            r_state    <= ACCUM;
                            r_ones_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SET_W'(1);
                        end
                    end
                end
                ACCUM: begin
                    if (!i_enable) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_div_cnt <= '0;
                        r_mic_clk <= 1'b0;
                    end else if (w_bit_tick && w_window_end) begin
                        if (fifo.full) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_sample <= w_word;
                            r_wr     <= 1'b1;
                            r_stb    <= 1'b0;
                            r_state  <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    if (!r_stb) begin
                        r_stb <= 1'b1;
                    end else begin
                        r_wr <= 1'b0;
                        if (i_enable) begin
                            r_state <= ACCUM;
                        end else begin
                            r_state   <= IDLE;
                            r_busy    <= 1'b0;
                            r_div_cnt <= '0;
                            r_mic_clk <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
